reg_file: RTL and testbench

- Y86-64 program register file for the SEQ processor. It sits directly upstream of the ALU: decode reads valA/valB here, and they feed the ALU operand inputs.
- Write-back stores the ALU result (valE) and the memory result (valM) back into the file.
- 15 architectural 64-bit registers (IDs 0x0–0xE). ID 0xF means "no register".

---
 rtl/reg_file.sv | 74 +++++++
 tb/tb_reg_file.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Y86-64 program register file: fifteen WIDTH-bit registers, two combinational
// read ports plus a debug read port, and dual write-back ports (E and M).
module reg_file #(
    parameter int unsigned        WIDTH    = 64,
    parameter logic [WIDTH-1:0]   RSP_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    input  logic [3:0]       dstE,
    input  logic [WIDTH-1:0] valE,
    input  logic [3:0]       dstM,
    input  logic [WIDTH-1:0] valM,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_val
);

    localparam int unsigned NREGS  = 15;
    localparam logic [3:0]  RNONE  = 4'hF;
    localparam int unsigned RSP_ID = 4;

    // Sixteen-entry read view; slot 0xF is hard-wired to zero so every
    // 4-bit ID selects something defined and "no register" reads as 0.
    logic [15:0][WIDTH-1:0] rd_view;

    assign rd_view[15] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [3:0] ID = 4'(gi);

            logic [WIDTH-1:0] q_reg;
            logic [WIDTH-1:0] q_next;

            // Port M is evaluated last so it overrides port E on a shared
            // destination (popq %rsp relies on this).
            always_comb begin
                q_next = q_reg;
                if (dstE == ID && dstE != RNONE)
                    q_next = valE;
                if (dstM == ID && dstM != RNONE)
                    q_next = valM;
            end

            if (gi == RSP_ID) begin : g_rsp
                always_ff @(posedge clk) begin
                    if (rst)
                        q_reg <= RSP_INIT;
                    else
                        q_reg <= q_next;
                end
            end else begin : g_gpr
                always_ff @(posedge clk) begin
                    if (rst)
                        q_reg <= '0;
                    else
                        q_reg <= q_next;
                end
            end

            assign rd_view[gi] = q_reg;
        end
    endgenerate

    // Reads see the stored array only: no bypass from the write ports.
    assign valA    = rd_view[srcA];
    assign valB    = rd_view[srcB];
    assign dbg_val = rd_view[dbg_sel];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expected read data is queued as each read is
// driven and compared once the combinational outputs have settled.
module tb_reg_file;

    localparam int unsigned  WIDTH = 64;
    localparam logic [63:0]  RSP0  = 64'h100;
    localparam logic [3:0]   RNONE = 4'hF;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       srcA, srcB, dstE, dstM, dbg_sel;
    logic [WIDTH-1:0] valA, valB, valE, valM, dbg_val;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        int          port;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb[$];
    logic [63:0] model [15];

    reg_file #(.WIDTH(WIDTH), .RSP_INIT(RSP0)) dut (
        .clk     (clk),
        .rst     (rst),
        .srcA    (srcA),
        .srcB    (srcB),
        .valA    (valA),
        .valB    (valB),
        .dstE    (dstE),
        .valE    (valE),
        .dstM    (dstM),
        .valM    (valM),
        .dbg_sel (dbg_sel),
        .dbg_val (dbg_val)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, obs);
        end
    endtask

    task automatic drain();
        sb_t         e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                0:       obs = valA;
                1:       obs = valB;
                default: obs = dbg_val;
            endcase
            check_val(e.tag, obs, e.exp);
        end
    endtask

    // port: 0 = A, 1 = B, 2 = debug
    task automatic rd(input int port, input logic [3:0] id, input logic [63:0] exp, input string tag);
        sb_t e;
        case (port)
            0:       srcA    = id;
            1:       srcB    = id;
            default: dbg_sel = id;
        endcase
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
        #1;
        drain();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) model[i] = 64'h0;
        model[4] = RSP0;
    endtask

    task automatic wr(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
        dstE = de; valE = ve;
        dstM = dm; valM = vm;
        tick();
        dstE = RNONE;
        dstM = RNONE;
        if (de != RNONE) model[de] = ve;
        if (dm != RNONE) model[dm] = vm;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++)
            rd(2, 4'(i), (i == 15) ? 64'h0 : model[i], $sformatf("%s[%0d]", tag, i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        srcA = RNONE; srcB = RNONE; dbg_sel = RNONE;
        dstE = RNONE; dstM = RNONE; valE = '0; valM = '0;
        @(negedge clk);

        // Reset with a concurrent write that must be discarded
        rst = 1'b1; dstE = 4'h0; valE = 64'd5;
        tick();
        rst = 1'b0; dstE = RNONE;
        model_reset();
        sweep("reset");
        rd(0, 4'h0, 64'h0, "rax_discarded");
        rd(0, 4'h4, 64'h100, "rsp_init");

        // Dual write to distinct registers
        wr(4'h2, 64'hDEAD_BEEF, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(0, 4'h2, 64'h0000_0000_DEAD_BEEF, "dual_a");
        rd(1, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, "dual_b");

        // Same destination on both ports: M wins
        wr(4'h4, 64'h108, 4'h4, 64'h55);
        rd(2, 4'h4, 64'h55, "collide_m_wins");

        // Read returns old value until the edge
        wr(4'h1, 64'd7, RNONE, 64'h0);
        dstE = 4'h1; valE = 64'd9;
        rd(0, 4'h1, 64'd7, "read_old");
        @(posedge clk);
        rd(0, 4'h1, 64'd9, "read_new");
        @(negedge clk);
        dstE = RNONE;
        model[1] = 64'd9;

        // No-register ID on reads and writes
        rd(0, RNONE, 64'h0, "srcA_none");
        rd(1, RNONE, 64'h0, "srcB_none");
        wr(RNONE, 64'hAAAA_AAAA_AAAA_AAAA, RNONE, 64'hBBBB_BBBB_BBBB_BBBB);
        sweep("noreg");

        // Same ID on all three ports
        srcA = 4'h2; srcB = 4'h2;
        rd(2, 4'h2, 64'hDEAD_BEEF, "same_id_dbg");
        rd(0, 4'h2, 64'hDEAD_BEEF, "same_id_a");
        rd(1, 4'h2, 64'hDEAD_BEEF, "same_id_b");

        // Load ID*0x11 everywhere, then reset mid-program with live writes
        for (int i = 0; i < 15; i += 2)
            wr(4'(i), 64'(i * 'h11), (i + 1 < 15) ? 4'(i + 1) : RNONE, 64'((i + 1) * 'h11));
        sweep("load");
        rst = 1'b1;
        dstE = 4'hE; valE = 64'hFFFF;
        dstM = 4'h3; valM = 64'h77;
        tick();
        rst = 1'b0; dstE = RNONE; dstM = RNONE;
        model_reset();
        sweep("midrst");
        wr(4'hE, 64'h1234, RNONE, 64'h0);
        rd(2, 4'hE, 64'h1234, "r14_after_rst");
        rd(0, 4'h4, 64'h100, "rsp_after_rst");

        if (sb.size() != 0) check_val("sb_empty", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
